// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Revision: 1.0 - initial release
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int REQ_IDX_WIDTH = 2,
  parameter int DATA_WIDTH    = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int LEVEL_WIDTH   = 4,
  parameter int MAX_BURST     = 4,
  parameter int BURST_WIDTH   = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            fifo_wr_vld,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  input  logic                            fifo_rd_fire,
  output logic [LEVEL_WIDTH-1:0]          fifo_level,
  output logic                            err_underflow
);

  localparam logic [0:0]               c_IDLE      = 1'b0;
  localparam logic [0:0]               c_BURST     = 1'b1;
  localparam logic [LEVEL_WIDTH-1:0]   c_DEPTH     = LEVEL_WIDTH'(FIFO_DEPTH);
  localparam logic [BURST_WIDTH-1:0]   c_LAST_BEAT = BURST_WIDTH'(MAX_BURST - 1);
  localparam logic [REQ_IDX_WIDTH-1:0] c_LAST_RST  = REQ_IDX_WIDTH'(NUM_REQ - 1);
  localparam logic [REQ_IDX_WIDTH:0]   c_NREQ      = (REQ_IDX_WIDTH + 1)'(NUM_REQ);

  logic [0:0]               state_q, state_d;
  logic [REQ_IDX_WIDTH-1:0] owner_q, owner_d;
  logic [REQ_IDX_WIDTH-1:0] last_q, last_d;
  logic [BURST_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [LEVEL_WIDTH-1:0]   level_q, level_d;
  logic                     err_q, err_d;

  logic [DATA_WIDTH-1:0]    w_slice [NUM_REQ];
  logic [REQ_IDX_WIDTH-1:0] w_winner;
  logic [REQ_IDX_WIDTH:0]   w_sum;
  logic                     w_found;
  logic                     w_space;
  logic                     w_beat;
  logic                     w_rd_ok;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search upward from last+1, wrapping, so the previous owner is considered last.
  always_comb begin
    w_winner = last_q;
    w_found  = 1'b0;
    w_sum    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, last_q} + (REQ_IDX_WIDTH + 1)'(k);
      if (w_sum >= c_NREQ) w_sum = w_sum - c_NREQ;
      if (!w_found && req[w_sum[REQ_IDX_WIDTH-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[REQ_IDX_WIDTH-1:0];
      end
    end
  end

  assign w_space      = (level_q < c_DEPTH);
  assign w_beat       = (state_q == c_BURST) && req[owner_q] && w_space;
  assign fifo_wr_vld  = w_beat;
  assign fifo_wr_data = w_slice[owner_q];
  assign gnt          = gnt_q;
  assign fifo_level   = level_q;
  assign err_underflow = err_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    gnt_d      = gnt_q;
    case (state_q)
      c_IDLE: begin
        if (|req) begin
          state_d    = c_BURST;
          owner_d    = w_winner;
          beat_cnt_d = '0;
          gnt_d      = NUM_REQ'(1) << w_winner;
        end
      end
      default: begin
        if (w_beat) beat_cnt_d = beat_cnt_q + 1'b1;
        // Stalled cycles (no space) never reach the burst limit.
        if (!req[owner_q] || (w_beat && (beat_cnt_q == c_LAST_BEAT))) begin
          state_d = c_IDLE;
          gnt_d   = '0;
          last_d  = owner_q;
        end
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    err_d   = err_q;
    w_rd_ok = fifo_rd_fire && (level_q != '0);
    if (w_beat && !w_rd_ok)      level_d = level_q + 1'b1;
    else if (!w_beat && w_rd_ok) level_d = level_q - 1'b1;
    if (fifo_rd_fire && (level_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_IDLE;
      owner_q    <= '0;
      last_q     <= c_LAST_RST;
      beat_cnt_q <= '0;
      gnt_q      <= '0;
      level_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
      level_q    <= level_d;
      err_q      <= err_d;
    end
  end

endmodule

`default_nettype wire
